// File: rtl/vend_pkg.sv
// Shared types and defaults for the vending controller.
package vend_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHaveRow,
        StCheck,
        StPay,
        StVend,
        StRefund
    } state_e;

    localparam logic PRG_TGT_PRICE = 1'b0;
    localparam logic PRG_TGT_STOCK = 1'b1;

    localparam int unsigned DEF_N_ROWS        = 4;
    localparam int unsigned DEF_N_COLS        = 4;
    localparam int unsigned DEF_PRICE_W       = 16;
    localparam int unsigned DEF_STOCK_W       = 8;
    localparam int unsigned DEF_DEFAULT_PRICE = 100;
    localparam int unsigned DEF_STOCK_INIT    = 10;
    localparam int unsigned DEF_TIMEOUT_CYC   = 1000;

endpackage

// File: rtl/vend_table.sv
// Per-slot price and stock register file: one write port, one combinational read port and a
// decrement port; a stock write to a slot overrides a same-cycle decrement of that slot.
module vend_table
    import vend_pkg::*;
#(
    parameter int unsigned SEL_W         = 4,
    parameter int unsigned PRICE_W       = DEF_PRICE_W,
    parameter int unsigned STOCK_W       = DEF_STOCK_W,
    parameter int unsigned DEFAULT_PRICE = DEF_DEFAULT_PRICE,
    parameter int unsigned STOCK_INIT    = DEF_STOCK_INIT
) (
    input  logic               CLK,
    input  logic               I_RESET,
    input  logic               wr_en,
    input  logic               wr_tgt,
    input  logic [SEL_W-1:0]   wr_addr,
    input  logic [PRICE_W-1:0] wr_data,
    input  logic [SEL_W-1:0]   rd_addr,
    output logic [PRICE_W-1:0] rd_price,
    output logic [STOCK_W-1:0] rd_stock,
    input  logic               dec_en,
    input  logic [SEL_W-1:0]   dec_addr
);

    localparam int unsigned NUM_SLOTS = 2 ** SEL_W;

    logic [PRICE_W-1:0] price_q [NUM_SLOTS];
    logic [STOCK_W-1:0] stock_q [NUM_SLOTS];

    always_ff @(posedge CLK) begin
        if (I_RESET) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                price_q[i] <= PRICE_W'(DEFAULT_PRICE);
                stock_q[i] <= STOCK_W'(STOCK_INIT);
            end
        end else begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                if (wr_en && wr_tgt == PRG_TGT_PRICE && wr_addr == SEL_W'(i)) begin
                    price_q[i] <= wr_data;
                end
                if (wr_en && wr_tgt == PRG_TGT_STOCK && wr_addr == SEL_W'(i)) begin
                    stock_q[i] <= wr_data[STOCK_W-1:0];
                end else if (dec_en && dec_addr == SEL_W'(i) && stock_q[i] != '0) begin
                    stock_q[i] <= stock_q[i] - STOCK_W'(1);
                end
            end
        end
    end

    assign rd_price = price_q[rd_addr];
    assign rd_stock = stock_q[rd_addr];

endmodule

// File: rtl/vending_core_p.sv
// Vending controller: keypad selection FSM, saturating coin credit, vend/refund payout and an
// inactivity timeout, backed by a programmable price/stock table.
module vending_core_p
    import vend_pkg::*;
#(
    parameter int unsigned N_ROWS        = DEF_N_ROWS,
    parameter int unsigned N_COLS        = DEF_N_COLS,
    parameter int unsigned PRICE_W       = DEF_PRICE_W,
    parameter int unsigned STOCK_W       = DEF_STOCK_W,
    parameter int unsigned DEFAULT_PRICE = DEF_DEFAULT_PRICE,
    parameter int unsigned STOCK_INIT    = DEF_STOCK_INIT,
    parameter int unsigned TIMEOUT_CYC   = DEF_TIMEOUT_CYC,
    localparam int unsigned ROW_W        = $clog2(N_ROWS),
    localparam int unsigned COL_W        = $clog2(N_COLS),
    localparam int unsigned SEL_W        = ROW_W + COL_W
) (
    input  logic               CLK,
    input  logic               I_RESET,
    input  logic [N_ROWS-1:0]  I_ROW_KEY,
    input  logic [N_COLS-1:0]  I_COL_KEY,
    input  logic               I_COIN_VALID,
    input  logic [PRICE_W-1:0] I_COIN_VAL,
    input  logic               I_CANCEL,
    input  logic               I_PRG_WE,
    input  logic               I_PRG_TGT,
    input  logic [SEL_W-1:0]   I_PRG_ADDR,
    input  logic [PRICE_W-1:0] I_PRG_DATA,
    output logic [PRICE_W-1:0] O_CREDIT,
    output logic [PRICE_W-1:0] O_PRICE,
    output logic [SEL_W-1:0]   O_SEL,
    output logic               O_SUCCESS,
    output logic [PRICE_W-1:0] O_CHANGE,
    output logic               O_CHANGE_VALID,
    output logic               O_SOLD_OUT
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d, row_idx;
    logic [COL_W-1:0]   col_q, col_d, col_idx;
    logic [PRICE_W-1:0] credit_q, credit_d, price_q, price_d, change_q, change_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               success_q, success_d, chg_vld_q, chg_vld_d, sold_q, sold_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               row_vld, col_vld, activity, tmo_hit, paid;
    logic [PRICE_W:0]   coin_sum;
    logic [PRICE_W-1:0] credit_add, coin_only, rd_price;
    logic [STOCK_W-1:0] rd_stock;

    // Multi-hot keys are treated as no key at all.
    always_comb begin
        row_idx = '0;
        col_idx = '0;
        for (int unsigned i = 0; i < N_ROWS; i++) if (I_ROW_KEY[i]) row_idx = ROW_W'(i);
        for (int unsigned i = 0; i < N_COLS; i++) if (I_COL_KEY[i]) col_idx = COL_W'(i);
    end
    assign row_vld = $onehot(I_ROW_KEY);
    assign col_vld = $onehot(I_COL_KEY);

    assign coin_sum   = {1'b0, credit_q} + {1'b0, I_COIN_VAL};
    assign credit_add = I_COIN_VALID ? (coin_sum[PRICE_W] ? '1 : coin_sum[PRICE_W-1:0])
                                     : credit_q;
    assign coin_only  = I_COIN_VALID ? I_COIN_VAL : '0;

    assign activity = row_vld | col_vld | I_COIN_VALID;
    assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) && !activity;
    assign paid     = credit_q >= rd_price;

    vend_table #(
        .SEL_W         (SEL_W),
        .PRICE_W       (PRICE_W),
        .STOCK_W       (STOCK_W),
        .DEFAULT_PRICE (DEFAULT_PRICE),
        .STOCK_INIT    (STOCK_INIT)
    ) u_table (
        .CLK      (CLK),
        .I_RESET  (I_RESET),
        .wr_en    (I_PRG_WE),
        .wr_tgt   (I_PRG_TGT),
        .wr_addr  (I_PRG_ADDR),
        .wr_data  (I_PRG_DATA),
        .rd_addr  ({row_q, (state_q == StHaveRow) ? col_idx : col_q}),
        .rd_price (rd_price),
        .rd_stock (rd_stock),
        .dec_en   (state_q == StVend),
        .dec_addr ({row_q, col_q})
    );

    always_ff @(posedge CLK) begin
        if (I_RESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (I_CANCEL)     state_d = StRefund;
                else if (row_vld) state_d = StHaveRow;
            end
            StHaveRow: begin
                if (I_CANCEL)     state_d = StRefund;
                else if (row_vld) state_d = StHaveRow;
                else if (col_vld) state_d = StCheck;
                else if (tmo_hit) state_d = StIdle;
            end
            StCheck: begin
                if (I_CANCEL)             state_d = StRefund;
                else if (rd_stock == '0)  state_d = StIdle;
                else if (paid)            state_d = StVend;
                else                      state_d = StPay;
            end
            StPay: begin
                if (I_CANCEL)     state_d = StRefund;
                else if (row_vld) state_d = StHaveRow;
                else if (paid)    state_d = StVend;
                else if (tmo_hit) state_d = StIdle;
            end
            StVend, StRefund: state_d = StIdle;
            default:          state_d = StIdle;
        endcase
    end

    always_comb begin
        row_d     = row_q;
        col_d     = col_q;
        credit_d  = credit_add;
        price_d   = price_q;
        sel_d     = sel_q;
        change_d  = change_q;
        success_d = 1'b0;
        chg_vld_d = 1'b0;
        sold_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!I_CANCEL && row_vld) row_d = row_idx;
            end
            StHaveRow: begin
                if (!I_CANCEL) begin
                    if (row_vld) begin
                        row_d = row_idx;
                    end else if (col_vld) begin
                        col_d   = col_idx;
                        price_d = rd_price;
                    end else if (tmo_hit) begin
                        price_d = '0;
                    end
                end
            end
            StCheck: begin
                if (!I_CANCEL) begin
                    if (rd_stock == '0) begin
                        sold_d  = 1'b1;
                        price_d = '0;
                    end else begin
                        price_d = rd_price;
                    end
                end
            end
            StPay: begin
                // O_PRICE follows the table so a reprogrammed price is visible immediately.
                if (!I_CANCEL) begin
                    if (row_vld) begin
                        row_d   = row_idx;
                        price_d = '0;
                    end else begin
                        price_d = (paid || !tmo_hit) ? rd_price : '0;
                    end
                end
            end
            StVend: begin
                success_d = 1'b1;
                chg_vld_d = 1'b1;
                sel_d     = {row_q, col_q};
                change_d  = credit_q - price_q;
                credit_d  = coin_only;
                price_d   = '0;
            end
            StRefund: begin
                chg_vld_d = 1'b1;
                change_d  = credit_q;
                credit_d  = coin_only;
                price_d   = '0;
            end
            default: ;
        endcase

        tmo_d = tmo_q + TMO_W'(1);
        if (state_d != state_q || activity || !(state_q inside {StHaveRow, StPay})) begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (I_RESET) begin
            row_q     <= '0;
            col_q     <= '0;
            credit_q  <= '0;
            price_q   <= '0;
            sel_q     <= '0;
            change_q  <= '0;
            success_q <= 1'b0;
            chg_vld_q <= 1'b0;
            sold_q    <= 1'b0;
            tmo_q     <= '0;
        end else begin
            row_q     <= row_d;
            col_q     <= col_d;
            credit_q  <= credit_d;
            price_q   <= price_d;
            sel_q     <= sel_d;
            change_q  <= change_d;
            success_q <= success_d;
            chg_vld_q <= chg_vld_d;
            sold_q    <= sold_d;
            tmo_q     <= tmo_d;
        end
    end

    assign O_CREDIT       = credit_q;
    assign O_PRICE        = price_q;
    assign O_SEL          = sel_q;
    assign O_SUCCESS      = success_q;
    assign O_CHANGE       = change_q;
    assign O_CHANGE_VALID = chg_vld_q;
    assign O_SOLD_OUT     = sold_q;

endmodule

// File: tb/tb_vending_core_p.sv
// Directed bench for vending_core_p: expected payout/sold-out events are queued as stimulus is
// driven and popped by a monitor whenever the DUT pulses one of its strobes.
module tb_vending_core_p;

    localparam int unsigned KIND_VEND   = 0;
    localparam int unsigned KIND_REFUND = 1;
    localparam int unsigned KIND_SOLD   = 2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [3:0]  sel;
        logic [15:0] chg;
    } ev_t;

    logic        CLK = 1'b0;
    logic        I_RESET;
    logic [3:0]  I_ROW_KEY, I_COL_KEY;
    logic        I_COIN_VALID, I_CANCEL, I_PRG_WE, I_PRG_TGT;
    logic [15:0] I_COIN_VAL, I_PRG_DATA;
    logic [3:0]  I_PRG_ADDR;
    logic [15:0] O_CREDIT, O_PRICE, O_CHANGE;
    logic [3:0]  O_SEL;
    logic        O_SUCCESS, O_CHANGE_VALID, O_SOLD_OUT;

    int  tests = 0;
    int  fails = 0;
    ev_t sb[$];

    vending_core_p #(
        .TIMEOUT_CYC (8)
    ) dut (
        .CLK            (CLK),
        .I_RESET        (I_RESET),
        .I_ROW_KEY      (I_ROW_KEY),
        .I_COL_KEY      (I_COL_KEY),
        .I_COIN_VALID   (I_COIN_VALID),
        .I_COIN_VAL     (I_COIN_VAL),
        .I_CANCEL       (I_CANCEL),
        .I_PRG_WE       (I_PRG_WE),
        .I_PRG_TGT      (I_PRG_TGT),
        .I_PRG_ADDR     (I_PRG_ADDR),
        .I_PRG_DATA     (I_PRG_DATA),
        .O_CREDIT       (O_CREDIT),
        .O_PRICE        (O_PRICE),
        .O_SEL          (O_SEL),
        .O_SUCCESS      (O_SUCCESS),
        .O_CHANGE       (O_CHANGE),
        .O_CHANGE_VALID (O_CHANGE_VALID),
        .O_SOLD_OUT     (O_SOLD_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic coin(input logic [15:0] v);
        I_COIN_VALID = 1'b1;
        I_COIN_VAL   = v;
        step();
        I_COIN_VALID = 1'b0;
        I_COIN_VAL   = '0;
    endtask

    task automatic row(input int r);
        I_ROW_KEY = 4'(1 << r);
        step();
        I_ROW_KEY = '0;
    endtask

    task automatic col(input int c);
        I_COL_KEY = 4'(1 << c);
        step();
        I_COL_KEY = '0;
    endtask

    task automatic cancel();
        I_CANCEL = 1'b1;
        step();
        I_CANCEL = 1'b0;
    endtask

    task automatic prg(input logic tgt, input logic [3:0] addr, input logic [15:0] data);
        I_PRG_WE   = 1'b1;
        I_PRG_TGT  = tgt;
        I_PRG_ADDR = addr;
        I_PRG_DATA = data;
        step();
        I_PRG_WE   = 1'b0;
    endtask

    task automatic push(input int unsigned kind, input logic [3:0] sel, input logic [15:0] chg);
        ev_t e;
        e.kind = 2'(kind);
        e.sel  = sel;
        e.chg  = chg;
        sb.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (!I_RESET && (O_SUCCESS || O_CHANGE_VALID || O_SOLD_OUT)) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {29'd0, O_SUCCESS, O_CHANGE_VALID, O_SOLD_OUT}, 0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("ev_success", 32'(O_SUCCESS), 32'(e.kind == 2'(KIND_VEND)));
                chk("ev_change_valid", 32'(O_CHANGE_VALID), 32'(e.kind != 2'(KIND_SOLD)));
                chk("ev_sold_out", 32'(O_SOLD_OUT), 32'(e.kind == 2'(KIND_SOLD)));
                if (e.kind == 2'(KIND_VEND)) chk("ev_sel", 32'(O_SEL), 32'(e.sel));
                if (e.kind != 2'(KIND_SOLD)) chk("ev_change", 32'(O_CHANGE), 32'(e.chg));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        I_RESET = 1'b1; I_ROW_KEY = '0; I_COL_KEY = '0; I_COIN_VALID = 1'b0; I_COIN_VAL = '0;
        I_CANCEL = 1'b0; I_PRG_WE = 1'b0; I_PRG_TGT = 1'b0; I_PRG_ADDR = '0; I_PRG_DATA = '0;
        idle(2);
        I_RESET = 1'b0;
        @(negedge CLK);
        chk("rst_credit", 32'(O_CREDIT), 0);
        chk("rst_price", 32'(O_PRICE), 0);
        chk("rst_sel", 32'(O_SEL), 0);
        chk("rst_change", 32'(O_CHANGE), 0);
        chk("rst_strobes", {29'd0, O_SUCCESS, O_CHANGE_VALID, O_SOLD_OUT}, 0);

        prg(1'b0, 4'h0, 16'd100);
        prg(1'b0, 4'h5, 16'd250);
        prg(1'b0, 4'hF, 16'd200);

        // A1 with exact credit
        coin(16'd100); row(0); push(KIND_VEND, 4'h0, 16'd0); col(0); idle(4);
        chk("a1_credit", 32'(O_CREDIT), 0);
        chk("a1_price", 32'(O_PRICE), 0);

        // B2 short of credit, then topped up while paying
        coin(16'd100); coin(16'd100); row(1); col(1); idle(2);
        chk("b2_pay_price", 32'(O_PRICE), 250);
        chk("b2_pay_credit", 32'(O_CREDIT), 200);
        push(KIND_VEND, 4'h5, 16'd0); coin(16'd25); coin(16'd25); idle(4);
        chk("b2_credit", 32'(O_CREDIT), 0);

        // last row key wins; change returned
        coin(16'd200); coin(16'd200); row(0); row(1); row(3);
        push(KIND_VEND, 4'hF, 16'd200); col(3); idle(4);
        chk("d4_credit", 32'(O_CREDIT), 0);

        // D4 stock should now be 9: nine more vends, then sold out
        for (int k = 0; k < 9; k++) begin
            coin(16'd200); row(3); push(KIND_VEND, 4'hF, 16'd0); col(3); idle(3);
        end
        coin(16'd200); row(3); push(KIND_SOLD, 4'h0, 16'd0); col(3); idle(3);
        chk("empty_credit", 32'(O_CREDIT), 200);
        chk("empty_price", 32'(O_PRICE), 0);
        chk("empty_change_held", 32'(O_CHANGE), 0);
        push(KIND_REFUND, 4'h0, 16'd200); cancel(); idle(3);

        // stock programmed to zero
        prg(1'b1, 4'hF, 16'd2); prg(1'b1, 4'hF, 16'd0);
        coin(16'd300); row(3); push(KIND_SOLD, 4'h0, 16'd0); col(3); idle(3);
        chk("prg0_credit", 32'(O_CREDIT), 300);
        push(KIND_REFUND, 4'h0, 16'd300); cancel(); idle(3);

        // cancel with a pending row
        coin(16'd150); row(2); push(KIND_REFUND, 4'h0, 16'd150); cancel(); idle(3);
        chk("cancel_credit", 32'(O_CREDIT), 0);
        chk("cancel_change_held", 32'(O_CHANGE), 150);

        // stock write in the vend cycle overrides the decrement
        prg(1'b1, 4'hF, 16'd5);
        coin(16'd200); row(3); push(KIND_VEND, 4'hF, 16'd0); col(3);
        step(); prg(1'b1, 4'hF, 16'd1); idle(2);
        coin(16'd200); row(3); push(KIND_VEND, 4'hF, 16'd0); col(3); idle(3);
        coin(16'd200); row(3); push(KIND_SOLD, 4'h0, 16'd0); col(3); idle(3);
        push(KIND_REFUND, 4'h0, 16'd200); cancel(); idle(3);

        // timeout boundaries with TIMEOUT_CYC = 8
        coin(16'd50); row(0); idle(8); col(0);
        @(negedge CLK);
        chk("tmo_expired_price", 32'(O_PRICE), 0);
        idle(1); row(0); idle(7); col(0);
        @(negedge CLK);
        chk("tmo_alive_price", 32'(O_PRICE), 100);
        idle(12);
        chk("tmo_pay_price", 32'(O_PRICE), 0);
        chk("tmo_pay_credit", 32'(O_CREDIT), 50);
        push(KIND_REFUND, 4'h0, 16'd50); cancel(); idle(3);

        // credit saturation
        coin(16'hFFF0); coin(16'h0100);
        @(negedge CLK);
        chk("sat_credit", 32'(O_CREDIT), 32'h0000FFFF);
        push(KIND_REFUND, 4'h0, 16'hFFFF); cancel(); idle(3);

        // reset landing on the vend edge: no payout, credit gone
        coin(16'd100); row(0); col(0); step();
        I_RESET = 1'b1; step(); I_RESET = 1'b0;
        @(negedge CLK);
        chk("rstvend_credit", 32'(O_CREDIT), 0);
        chk("rstvend_change", 32'(O_CHANGE), 0);
        chk("rstvend_strobes", {29'd0, O_SUCCESS, O_CHANGE_VALID, O_SOLD_OUT}, 0);
        idle(3);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vending_core_p.md
# vending_core_p

Parametrised successor vending controller: an N_ROWS x N_COLS keypad selection FSM with per-coin credit accumulation, a run-time programmable price table, per-slot stock counters, a cancel/refund path and an inactivity timeout. It sits between the keypad/coin-acceptor front end and the dispenser/change-hopper back end. Its strobes are single-cycle pulses consumed by those external blocks.

## Interface
- N_ROWS, 4: letter keys; power of 2, at least 2.
- N_COLS, 4: digit keys; power of 2, at least 2.
- PRICE_W, 16: width of prices, credit and change, in cents.
- STOCK_W, 8: width of the per-slot stock counter.
- DEFAULT_PRICE, 100: price loaded into every slot at reset.
- STOCK_INIT, 10: stock loaded into every slot at reset.
- TIMEOUT_CYC, 1000: inactivity limit in cycles; at least 2.
- SEL_W is derived as log2(N_ROWS)+log2(N_COLS). Slot index = {row, col}.

Ports:
- CLK  in  1  clock.
- I_RESET  in  1  reset, synchronous, active-high.
- I_ROW_KEY  in  N_ROWS  letter keys; at most one bit high.
- I_COL_KEY  in  N_COLS  digit keys; at most one bit high.
- I_COIN_VALID  in  1  coin strobe; one coin per cycle.
- I_COIN_VAL  in  PRICE_W  value of the coin presented with I_COIN_VALID.
- I_CANCEL  in  1  refund request.
- I_PRG_WE  in  1  table write enable.
- I_PRG_TGT  in  1  write target: 0 = price, 1 = stock.
- I_PRG_ADDR  in  SEL_W  slot to write.
- I_PRG_DATA  in  PRICE_W  write data; stock takes the low STOCK_W bits.
- O_CREDIT  out  PRICE_W  current credit.
- O_PRICE  out  PRICE_W  price of the current selection; 0 when no selection.
- O_SEL  out  SEL_W  slot index of the last vend.
- O_SUCCESS  out  1  one-cycle vend pulse.
- O_CHANGE  out  PRICE_W  last change or refund amount; held until the next payout.
- O_CHANGE_VALID  out  1  one-cycle payout pulse.
- O_SOLD_OUT  out  1  one-cycle pulse when the selected slot has zero stock.

## Operation
States: IDLE, HAVE_ROW, CHECK, PAY, VEND, REFUND.

- **IDLE:** any row key latches the row and moves to HAVE_ROW.
- **HAVE_ROW:** a row key overwrites the latched row; the last key wins. A column key latches the column, loads O_PRICE from the table and moves to CHECK.
- **CHECK:**
  - If stock is 0: pulse O_SOLD_OUT, set O_PRICE to 0, go to IDLE.
  - Else if credit >= price: go to VEND.
  - Else: go to PAY.
- **PAY:** compares credit against price every cycle and moves to VEND once credit >= price. A row key restarts selection in HAVE_ROW.
- **VEND (one cycle):**
  - Pulse O_SUCCESS and O_CHANGE_VALID.
  - O_SEL = slot; O_CHANGE = credit - price.
  - Credit is set to the coin arriving in this cycle, else 0.
  - Stock of the slot is decremented; O_PRICE is set to 0; go to IDLE.
- **REFUND (one cycle):**
  - O_CHANGE = credit (0 is allowed); pulse O_CHANGE_VALID.
  - Credit and O_PRICE are set to 0; go to IDLE.
  - A coin arriving in this cycle becomes the new credit.
- **I_CANCEL** in IDLE, HAVE_ROW, CHECK or PAY goes to REFUND. Cancel has priority over keys and over the CHECK decision. It is ignored in VEND and REFUND.
- **Coins** are added to credit in every state except VEND and REFUND. The sum saturates at 2^PRICE_W-1.
- **Timeout:** a counter runs in HAVE_ROW and PAY and clears on any key, coin or state change. On reaching TIMEOUT_CYC it returns to IDLE and clears O_PRICE. Credit is retained.
- **Programming writes** are accepted in any state.
  - A price write to the slot currently in PAY takes effect in the next comparison.
  - A stock write and a VEND decrement to the same slot in the same cycle: the write wins.
- Keys with more than one bit set are ignored.

## Timing
- Reset applies on the first CLK edge with I_RESET high:
  - All outputs are 0 and state is IDLE.
  - Every price = DEFAULT_PRICE; every stock = STOCK_INIT.
- Reset mid-vend discards credit and gives no payout.
- All outputs are registered.
- Latency from a column key sampled at edge k with sufficient credit:
  - CHECK is entered after edge k.
  - VEND is entered after edge k+1.
  - O_SUCCESS is high for exactly one cycle after edge k+2.
- Price and stock reads are combinational from the table and registered into O_PRICE.

## Structure
- Package vend_pkg holds the state enum, the PRG_TGT_PRICE / PRG_TGT_STOCK constants and the default parameter values.
- Sub-module vend_table: a 2^SEL_W-entry price and stock register file with a write port, a combinational read port and a decrement port, where a write has priority over a decrement.

## Test plan
- Default parameters, prices reprogrammed to A1=100, B2=250, D4=200:
  - Coin 100, A, 1 -> O_SUCCESS pulse, O_SEL=0000, O_CHANGE=0, O_CREDIT=0.
- B, 2 with credit 200 -> PAY with O_PRICE=250, no success. Then coin 25 twice -> O_SUCCESS, O_SEL=0101, O_CHANGE=0.
- Coins totalling 400, then A, B, D, 4 -> O_SEL=1111, O_CHANGE=200, and D4 stock decremented to 9.
- D4 stock programmed to 0, credit 300, D, 4 -> O_SOLD_OUT pulse, no success, O_CREDIT=300.
- Credit 150, C, then I_CANCEL -> O_CHANGE=150 with O_CHANGE_VALID, O_CREDIT=0.
- TIMEOUT_CYC=8, A, then 8 idle cycles -> back to IDLE, O_PRICE=0, credit kept. Also a credit saturation check at 0xFFFF.
